cdb_wb_queue: RTL and testbench

//  Per-functional-unit writeback buffering ahead of the CDB round-robin arbiter.

---
 rtl/cdb_wb_queue_pkg.sv | 14 +
 rtl/cdb_wb_queue_if.sv | 28 ++
 rtl/cdb_wb_queue_wb_fifo.sv | 55 +++++
 rtl/cdb_wb_queue.sv | 99 +++++++++
 tb/tb_cdb_wb_queue.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_wb_queue_pkg.sv
// Shared types and default sizing for the CDB writeback queue.
package cdb_pkg;

    localparam int CDB_NUM_SRC = 4;
    localparam int CDB_DEPTH   = 4;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_TAG_W   = 6;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_wb_queue_if.sv
// FU result, arbiter request/grant and CDB broadcast signals of the writeback queue.
interface cdb_wb_queue_if
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = CDB_NUM_SRC
);
    logic [NUM_SRC-1:0]            fu_valid;
    logic [NUM_SRC*CDB_TAG_W-1:0]  fu_tag;
    logic [NUM_SRC*CDB_DATA_W-1:0] fu_data;
    logic [NUM_SRC-1:0]            fu_ready;
    logic [NUM_SRC-1:0]            arb_req;
    logic                          arb_req_valid;
    logic [NUM_SRC-1:0]            arb_grant;
    logic                          arb_grant_valid;
    logic                          cdb_valid;
    logic [CDB_TAG_W-1:0]          cdb_tag;
    logic [CDB_DATA_W-1:0]         cdb_data;

    modport master (
        output fu_valid, fu_tag, fu_data, arb_grant, arb_grant_valid,
        input  fu_ready, arb_req, arb_req_valid, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  fu_valid, fu_tag, fu_data, arb_grant, arb_grant_valid,
        output fu_ready, arb_req, arb_req_valid, cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/cdb_wb_queue_wb_fifo.sv
// Per-source result FIFO with explicit pointer wrap, so DEPTH need not be a power of two.
module wb_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = CDB_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  cdb_pkt_t                   i_din,
    output cdb_pkt_t                   o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    cdb_pkt_t         r_mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_rst && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/cdb_wb_queue.sv
// Writeback buffering ahead of the CDB arbiter: per-source FIFOs, grant qualify, registered CDB.
// Optional CDB_BYPASS_EN: an empty, granted source forwards its incoming result straight to the CDB.
module cdb_wb_queue
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = CDB_NUM_SRC,
    parameter int DEPTH   = CDB_DEPTH
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_flush,
    cdb_wb_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [NUM_SRC-1:0] w_full, w_empty, w_rdy, w_push, w_pop, w_req, w_sel, w_byp;
    logic [CNT_W-1:0]   w_count [NUM_SRC];
    cdb_pkt_t           w_din   [NUM_SRC];
    cdb_pkt_t           w_dout  [NUM_SRC];
    logic               w_onehot, w_grant_ok, w_grant_bad, w_any;
    cdb_pkt_t           w_pkt;
    logic               r_cdb_valid;
    cdb_pkt_t           r_cdb_pkt;

    assign w_onehot    = (bus.arb_grant != '0) &&
                         ((bus.arb_grant & (bus.arb_grant - NUM_SRC'(1))) == '0);
    assign w_grant_ok  = bus.arb_grant_valid & w_onehot;
    assign w_grant_bad = (bus.arb_grant_valid & ~w_onehot) |
                         (~bus.arb_grant_valid & (|bus.arb_grant));

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign w_din[g] = '{tag:  bus.fu_tag[g*CDB_TAG_W +: CDB_TAG_W],
                            data: bus.fu_data[g*CDB_DATA_W +: CDB_DATA_W]};
`ifdef CDB_BYPASS_EN
        assign w_byp[g] = w_empty[g] & bus.fu_valid[g] & ~i_flush;
`else
        assign w_byp[g] = 1'b0;
`endif
        // Ready comes from the registered count only: a same-cycle pop gives no credit.
        assign w_rdy[g]  = (w_count[g] < CNT_W'(DEPTH)) & ~i_flush;
        assign w_req[g]  = (~w_empty[g] | w_byp[g]) & ~i_flush;
        assign w_sel[g]  = w_grant_ok & bus.arb_grant[g] & w_req[g];
        assign w_pop[g]  = w_sel[g] & ~w_empty[g];
        assign w_push[g] = bus.fu_valid[g] & w_rdy[g] & ~(w_sel[g] & w_byp[g]);

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_flush (i_flush),
            .i_din   (w_din[g]),
            .o_dout  (w_dout[g]),
            .o_count (w_count[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    always_comb begin
        w_any = 1'b0;
        w_pkt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_sel[i]) begin
                w_any = 1'b1;
                w_pkt = w_empty[i] ? w_din[i] : w_dout[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cdb_valid <= 1'b0;
            r_cdb_pkt   <= '0;
        end else begin
            r_cdb_valid <= w_any;
            if (w_any) r_cdb_pkt <= w_pkt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!w_grant_bad)
                else $warning("cdb_wb_queue: illegal grant %b (valid=%b), no pop",
                              bus.arb_grant, bus.arb_grant_valid);
            for (int i = 0; i < NUM_SRC; i++) begin
                assert (!(w_push[i] && w_full[i]))
                    else $error("cdb_wb_queue: overflow push on source %0d", i);
            end
        end
    end

    assign bus.fu_ready      = w_rdy;
    assign bus.arb_req       = w_req;
    assign bus.arb_req_valid = ~i_flush & ~i_rst;
    assign bus.cdb_valid     = r_cdb_valid;
    assign bus.cdb_tag       = r_cdb_pkt.tag;
    assign bus.cdb_data      = r_cdb_pkt.data;
endmodule

// File: tb/tb_cdb_wb_queue.sv
// Directed bench for cdb_wb_queue: reset, latency, fill/wrap, round-robin drain, flush, illegal grant.
module tb_cdb_wb_queue;
    import cdb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cdb_wb_queue_if #(.NUM_SRC(4)) bus ();

    cdb_wb_queue #(.NUM_SRC(4), .DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int src, input logic [5:0] tag, input logic [31:0] data);
        bus.fu_tag[src*6 +: 6]    = tag;
        bus.fu_data[src*32 +: 32] = data;
    endtask

    task automatic grant(input logic [3:0] g);
        bus.arb_grant       = g;
        bus.arb_grant_valid = (g != 4'b0000);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        bus.fu_valid = '0;
        bus.fu_tag   = '0;
        bus.fu_data  = '0;
        grant(4'b0000);

        // 1 reset
        cyc();
        #1 check("req_valid_in_rst", bus.arb_req_valid, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        check("rst_cdb_valid", bus.cdb_valid, 1'b0);
        check("rst_cdb_tag", bus.cdb_tag, 6'd0);
        check("rst_cdb_data", bus.cdb_data, 32'd0);
        check("rst_fu_ready", bus.fu_ready, 4'b1111);
        check("rst_arb_req", bus.arb_req, 4'b0000);
        check("rst_req_valid", bus.arb_req_valid, 1'b1);

        // 2 single push on src2, granted the following cycle
        bus.fu_valid = 4'b0100;
        set_fu(2, 6'd5, 32'hA5);
        #1;
`ifndef CDB_BYPASS_EN
        check("push_cycle_req", bus.arb_req, 4'b0000);
`endif
        cyc();
        bus.fu_valid = 4'b0000;
        grant(4'b0100);
        #1 check("t1_req", bus.arb_req, 4'b0100);
        check("t1_cdb_valid", bus.cdb_valid, 1'b0);
        cyc();
        grant(4'b0000);
        #1;
        check("t2_cdb_valid", bus.cdb_valid, 1'b1);
        check("t2_cdb_tag", bus.cdb_tag, 6'd5);
        check("t2_cdb_data", bus.cdb_data, 32'hA5);
        check("t2_req", bus.arb_req, 4'b0000);
        cyc();
        check("t3_cdb_valid", bus.cdb_valid, 1'b0);
        check("t3_tag_hold", bus.cdb_tag, 6'd5);

        // 3 fill src0 with tags 1..4, pop while tag 5 waits, drain in order
        for (int k = 1; k <= 4; k++) begin
            bus.fu_valid = 4'b0001;
            set_fu(0, 6'(k), 32'h100 + 32'(k));
            cyc();
        end
        check("full_ready", bus.fu_ready, 4'b1110);
        check("full_req", bus.arb_req, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                check("drain_valid", bus.cdb_valid, 1'b1);
                check("drain_tag", bus.cdb_tag, 64'(k));
                check("drain_data", bus.cdb_data, 64'(32'h100 + 32'(k)));
            end
            bus.fu_valid = (k < 2) ? 4'b0001 : 4'b0000;
            set_fu(0, 6'd5, 32'h105);
            grant(4'b0001);
            #1;
            if (k == 0) check("full_pop_ready", bus.fu_ready[0], 1'b0);
            if (k == 1) check("after_pop_ready", bus.fu_ready[0], 1'b1);
            cyc();
        end
        grant(4'b0000);
        #1;
        check("drain5_valid", bus.cdb_valid, 1'b1);
        check("drain5_tag", bus.cdb_tag, 6'd5);
        check("drain5_data", bus.cdb_data, 32'h105);
        check("drained_req", bus.arb_req, 4'b0000);
        cyc();

        // 4 one entry per source, grants walk 0001..1000
        bus.fu_valid = 4'b1111;
        for (int s = 0; s < 4; s++) set_fu(s, 6'(10 + s), 32'h200 + 32'(s));
        cyc();
        bus.fu_valid = 4'b0000;
        #1 check("all_req", bus.arb_req, 4'b1111);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                check("rr_valid", bus.cdb_valid, 1'b1);
                check("rr_tag", bus.cdb_tag, 64'(9 + s));
                check("rr_data", bus.cdb_data, 64'(32'h1FF + 32'(s)));
            end
            grant(4'(1 << s));
            cyc();
        end
        grant(4'b0000);
        #1;
        check("rr_last_valid", bus.cdb_valid, 1'b1);
        check("rr_last_tag", bus.cdb_tag, 6'd13);
        check("rr_empty_req", bus.arb_req, 4'b0000);
        cyc();

        // 5 flush with three buffered entries and a grant in the same cycle
        bus.fu_valid = 4'b1011;
        set_fu(0, 6'd20, 32'h300);
        set_fu(1, 6'd21, 32'h301);
        set_fu(3, 6'd23, 32'h303);
        cyc();
        bus.fu_valid = 4'b0000;
        #1 check("pre_flush_req", bus.arb_req, 4'b1011);
        flush = 1'b1;
        grant(4'b0001);
        #1;
        check("flush_req", bus.arb_req, 4'b0000);
        check("flush_ready", bus.fu_ready, 4'b0000);
        check("flush_req_valid", bus.arb_req_valid, 1'b0);
        cyc();
        flush = 1'b0;
        grant(4'b0000);
        #1;
        check("post_flush_cdb_valid", bus.cdb_valid, 1'b0);
        check("post_flush_req", bus.arb_req, 4'b0000);
        check("post_flush_ready", bus.fu_ready, 4'b1111);
        check("post_flush_tag_hold", bus.cdb_tag, 6'd13);
        cyc();

        // 6 illegal two-hot grant: no pop, then legal drain
        bus.fu_valid = 4'b0011;
        set_fu(0, 6'd30, 32'h400);
        set_fu(1, 6'd31, 32'h401);
        cyc();
        bus.fu_valid = 4'b0000;
        grant(4'b0011);
        #1;
        check("illegal_req", bus.arb_req, 4'b0011);
        check("illegal_flag", dut.w_grant_bad, 1'b1);
        cyc();
        grant(4'b0001);
        #1;
        check("illegal_no_cdb", bus.cdb_valid, 1'b0);
        check("illegal_no_pop", bus.arb_req, 4'b0011);
        cyc();
        grant(4'b0010);
        #1 check("legal_tag0", bus.cdb_tag, 6'd30);
        cyc();
        grant(4'b0000);
        #1;
        check("legal_tag1", bus.cdb_tag, 6'd31);
        check("legal_data1", bus.cdb_data, 32'h401);
        cyc();

`ifdef CDB_BYPASS_EN
        // bypass: empty src1 granted in the same cycle as its result
        bus.fu_valid = 4'b0010;
        set_fu(1, 6'd40, 32'h500);
        grant(4'b0010);
        #1 check("byp_req", bus.arb_req, 4'b0010);
        cyc();
        bus.fu_valid = 4'b0000;
        grant(4'b0000);
        #1;
        check("byp_valid", bus.cdb_valid, 1'b1);
        check("byp_tag", bus.cdb_tag, 6'd40);
        check("byp_fifo_empty", bus.arb_req, 4'b0000);
        cyc();
`endif

        // reset mid-operation clears buffered data and the CDB registers
        bus.fu_valid = 4'b1000;
        set_fu(3, 6'd50, 32'h600);
        cyc();
        bus.fu_valid = 4'b0000;
        rst = 1'b1;
        grant(4'b1000);
        cyc();
        rst = 1'b0;
        grant(4'b0000);
        #1;
        check("mid_rst_valid", bus.cdb_valid, 1'b0);
        check("mid_rst_tag", bus.cdb_tag, 6'd0);
        check("mid_rst_data", bus.cdb_data, 32'd0);
        check("mid_rst_req", bus.arb_req, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
